// File: rtl/fp32_pkg.sv
// Shared types and constants for the sequential fp32 multiplier.
package fp32_pkg;

  typedef enum logic [1:0] {IDLE, MUL, NORM, PACK} mult_state_t;

  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_INF    = 2'b10;
  localparam logic [1:0] SP_NAN    = 2'b11;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam int          FP32_BIAS = 127;

endpackage

// File: rtl/fp32_round_pack.sv
// Rounds a normalised mantissa product to nearest-even and packs it into
// fp32, flushing out-of-range exponents to signed inf or signed zero.
// The leading one (product bit 46) is implicit, so only bits 45:0 come in.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic               sign,
  input  logic signed [9:0]  exp_in,
  input  logic [45:0]        frac,
  output logic [31:0]        result,
  output logic [1:0]         especial
);

  logic              guard;
  logic              round_bit;
  logic              sticky;
  logic              round_up;
  logic [24:0]       mant_r;
  logic [22:0]       mant_out;
  logic signed [9:0] exp_r;

  // RNE on guard/round/sticky, then exponent range check
  always_comb begin
    guard     = frac[22];
    round_bit = frac[21];
    sticky    = |frac[20:0];
    round_up  = guard & (round_bit | sticky | frac[23]);
    mant_r    = {2'b01, frac[45:23]} + {24'd0, round_up};
    exp_r     = mant_r[24] ? (exp_in + 10'sd1) : exp_in;
    mant_out  = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    result    = {sign, exp_r[7:0], mant_out};
    especial  = SP_NORMAL;
    if (exp_r >= 10'sd255) begin
      result   = {sign, 8'hFF, 23'd0};
      especial = SP_INF;
    end else if (exp_r <= 10'sd0) begin
      result   = {sign, 31'd0};
      especial = SP_ZERO;
    end
  end

endmodule

// File: rtl/fp32_mult_seq.sv
// Multi-cycle fp32 multiplier with start/done handshake.
//   state | meaning
//   IDLE  | waiting for start; operands unpacked and classified on accept
//   MUL   | shift-add of mantissas, BITS_PER_CYCLE multiplier bits per edge
//   NORM  | renormalise product when bit 47 is set
//   PACK  | round, range check, register result and pulse done
module fp32_mult_seq
  import fp32_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  especial
);

  localparam int         N        = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_LAST = 5'(N - 1);

  mult_state_t       state, next_state;
  logic [4:0]        cnt;
  logic [47:0]       mcand;
  logic [23:0]       mplier;
  logic [47:0]       prod;
  logic [47:0]       partial;
  logic signed [9:0] exp_q;
  logic signed [9:0] exp_calc;
  logic              sign_q;
  logic [1:0]        spec_q;
  logic [1:0]        cls;
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [31:0]       rp_result;
  logic [1:0]        rp_especial;

  // operand classification and biased exponent sum, valid on the accept edge
  always_comb begin
    a_zero   = (op_a[30:23] == 8'h00);
    b_zero   = (op_b[30:23] == 8'h00);
    a_inf    = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
    b_inf    = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
    a_nan    = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
    b_nan    = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
    exp_calc = $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]})
               - 10'(FP32_BIAS);
    cls      = SP_NORMAL;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      cls = SP_NAN;
    else if (a_inf || b_inf)
      cls = SP_INF;
    else if (a_zero || b_zero)
      cls = SP_ZERO;
  end

  assign partial = mcand * {24'd0, mplier[BITS_PER_CYCLE-1:0]};

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // next-state logic; specials bypass the mantissa datapath
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (cls == SP_NORMAL) ? MUL : PACK;
      MUL:  if (cnt == 5'd0) next_state = NORM;
      NORM: next_state = PACK;
      PACK: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  fp32_round_pack u_round_pack (
    .sign     (sign_q),
    .exp_in   (exp_q),
    .frac     (prod[45:0]),
    .result   (rp_result),
    .especial (rp_especial)
  );

  // datapath, iteration down-counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 5'd0;
      mcand    <= 48'd0;
      mplier   <= 24'd0;
      prod     <= 48'd0;
      exp_q    <= 10'sd0;
      sign_q   <= 1'b0;
      spec_q   <= SP_NORMAL;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'h0;
      especial <= SP_NORMAL;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sign_q <= op_a[31] ^ op_b[31];
          exp_q  <= exp_calc;
          spec_q <= cls;
          mcand  <= {24'd0, 1'b1, op_a[22:0]};
          mplier <= {1'b1, op_b[22:0]};
          prod   <= 48'd0;
          cnt    <= CNT_LAST;
          busy   <= 1'b1;
        end
        MUL: begin
          prod   <= prod + partial;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        NORM: if (prod[47]) begin
          // keep the shifted-out bit as sticky
          prod  <= {1'b0, prod[47:1]} | {47'd0, prod[0]};
          exp_q <= exp_q + 10'sd1;
        end
        PACK: begin
          busy <= 1'b0;
          done <= 1'b1;
          case (spec_q)
            SP_NAN:  result <= FP32_QNAN;
            SP_INF:  result <= {sign_q, 8'hFF, 23'd0};
            SP_ZERO: result <= {sign_q, 31'd0};
            default: result <= rp_result;
          endcase
          especial <= (spec_q == SP_NORMAL) ? rp_especial : spec_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mult_seq.sv
// Scoreboard bench for fp32_mult_seq: stimulus pushes expected results,
// monitors pop and compare whenever done pulses.
module tb_fp32_mult_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, start4 = 1'b0;
  logic [31:0] op_a = 32'h0, op_b = 32'h0, op_a4 = 32'h0, op_b4 = 32'h0;
  logic        busy, done, busy4, done4;
  logic [31:0] result, result4;
  logic [1:0]  especial, especial4;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  sp;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];

  fp32_mult_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .especial(especial)
  );

  fp32_mult_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op_a(op_a4), .op_b(op_b4),
    .busy(busy4), .done(done4), .result(result4), .especial(especial4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int want);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // monitor for the 1-bit-per-cycle instance
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) fail_now("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("especial", {30'd0, especial}, {30'd0, e.sp});
        check("latency", cyc - e.acc, e.lat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // monitor for the 4-bits-per-cycle instance
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done4) begin
      if (q4.size() == 0) fail_now("unexpected_done4", 1, 0);
      else begin
        e = q4.pop_front();
        check("result4", result4, e.res);
        check("especial4", {30'd0, especial4}, {30'd0, e.sp});
        check("latency4", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input bit use4, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [1:0] sp, input int lat);
    exp_t e;
    @(negedge clk);
    e.res = r; e.sp = sp; e.acc = cyc + 1; e.lat = lat;
    if (use4) begin
      op_a4 = a; op_b4 = b; start4 = 1'b1; q4.push_back(e);
    end else begin
      op_a = a; op_b = b; start = 1'b1; q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 || q4.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        fail_now("drain_timeout", q.size() + q4.size(), 0);
        q.delete();
        q4.delete();
        break;
      end
    end
  endtask

  logic [31:0] va [10] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'hC0000000,
                           32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h00000000,
                           32'h7F000000, 32'h00800000};
  logic [31:0] vb [10] = '{32'h40000000, 32'h3F800001, 32'h3F7FFFFF, 32'hC0400000,
                           32'h00000000, 32'h3F800000, 32'h40000000, 32'hC0000000,
                           32'h40000000, 32'h80800000};
  logic [31:0] vr [10] = '{32'h40400000, 32'h3F800002, 32'h3F800000, 32'h40C00000,
                           32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
                           32'h7F800000, 32'h80000000};
  logic [1:0]  vs [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b01,
                           2'b10, 2'b01};
  int          vl [10] = '{26, 26, 26, 26, 1, 1, 1, 1, 26, 26};

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k;
    int   n;

    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_especial", {30'd0, especial}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(1'b0, va[i], vb[i], vr[i], vs[i], vl[i]);
      drain(60);
    end

    issue(1'b1, 32'hBF800000, 32'h40400000, 32'hC0400000, 2'b00, 8);
    drain(30);
    issue(1'b1, 32'h3FC00000, 32'h40000000, 32'h40400000, 2'b00, 8);
    drain(30);

    // start held high: one accept per IDLE visit
    @(negedge clk);
    op_a = 32'h3FC00000; op_b = 32'h40000000; start = 1'b1;
    k = cyc + 1;
    e.res = 32'h40400000; e.sp = 2'b00; e.lat = 26;
    e.acc = k;      q.push_back(e);
    e.acc = k + 27; q.push_back(e);
    repeat (40) @(negedge clk);
    start = 1'b0;
    drain(80);
    repeat (30) @(negedge clk);

    // operand changes and start pulses while busy are ignored
    issue(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, 26);
    repeat (5) @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h00000000; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    drain(60);
    repeat (5) @(negedge clk);

    // back-to-back: start in the done cycle
    issue(1'b0, 32'h40000000, 32'h40000000, 32'h40800000, 2'b00, 26);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("b2b_done_timeout", 0, 1);
    else begin
      op_a = 32'hBF800000; op_b = 32'h3FC00000; start = 1'b1;
      e.res = 32'hBFC00000; e.sp = 2'b00; e.acc = cyc + 1; e.lat = 26;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
    end
    drain(60);

    // reset in the middle of MUL
    issue(1'b0, 32'h40000000, 32'h40000000, 32'h40800000, 2'b00, 26);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    q.delete();
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_especial", {30'd0, especial}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_abort_busy", {31'd0, busy}, 32'd0);
    issue(1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00, 26);
    drain(60);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
